// File: rtl/simon_host_bridge.sv
// Purpose: byte-parallel host bridge for the bit-serial SIMON 128/128 core (collect, load, run, capture, drain).
// Latency: last input byte to first out_valid = BLOCK_BITS + KEY_BITS + R + BLOCK_BITS + 1 cycles (R = RUN cycles incl. first core_valid).
// Backpressure: in_valid/in_ready only in COLLECT; out_valid/out_ready in DRAIN holds out_data stable while stalled.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_data/in_valid/in_ready         host plaintext byte stream
//   out_data/out_valid/out_ready      host ciphertext byte stream
//   busy                              high in any state other than COLLECT
//   err                               one-cycle pulse when the RUN watchdog aborts
//   core_data_in, core_data_rdy       serial bit and command to the core (00 idle, 01 pt, 10 key, 11 run)
//   core_cipher_out, core_valid       serial ciphertext bit and valid from the core

module simon_host_bridge #(
    parameter int BLOCK_BITS = 128,
    parameter int KEY_BITS   = 128,
    parameter int TIMEOUT    = 16384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       err,
    output logic       core_data_in,
    output logic [1:0] core_data_rdy,
    input  logic       core_cipher_out,
    input  logic       core_valid
);

    localparam int NB   = BLOCK_BITS / 8;
    localparam int MAXB = (BLOCK_BITS > KEY_BITS) ? BLOCK_BITS : KEY_BITS;
    localparam int CW   = $clog2(MAXB) + 1;
    localparam int WW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_PT   = 2'b01;
    localparam logic [1:0] CMD_KEY  = 2'b10;
    localparam logic [1:0] CMD_RUN  = 2'b11;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_LOAD_PT,
        ST_LOAD_KEY,
        ST_RUN,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t                  state;
    logic [BLOCK_BITS-1:0]   blk;
    logic [BLOCK_BITS-1:0]   ct;
    logic [CW-1:0]           bit_cnt;
    logic [4:0]              byte_cnt;
    logic [WW-1:0]           wdog;

    // Plaintext enters at the top and shifts down a byte per accept, so after
    // the last byte, byte n sits at blk[8n+7:8n]. During LOAD_PT the block
    // shifts down one bit per cycle and bit 0 is always the one being sent.
    logic [BLOCK_BITS-1:0]   blk_shift;
    assign blk_shift = {in_data, blk[BLOCK_BITS-1:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_COLLECT;
            blk           <= '0;
            ct            <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            wdog          <= '0;
            in_ready      <= 1'b0;
            out_data      <= 8'h00;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            core_data_in  <= 1'b0;
            core_data_rdy <= CMD_IDLE;
        end else begin
            err <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    in_ready      <= 1'b1;
                    busy          <= 1'b0;
                    out_valid     <= 1'b0;
                    core_data_in  <= 1'b0;
                    core_data_rdy <= CMD_IDLE;
                    if (in_valid && in_ready) begin
                        blk <= blk_shift;
                        if (byte_cnt == 5'(NB - 1)) begin
                            state         <= ST_LOAD_PT;
                            byte_cnt      <= '0;
                            bit_cnt       <= '0;
                            in_ready      <= 1'b0;
                            busy          <= 1'b1;
                            core_data_rdy <= CMD_PT;
                            // Bit 0 must be on the wire in the first LOAD_PT cycle.
                            core_data_in  <= blk_shift[0];
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                        end
                    end
                end

                ST_LOAD_PT: begin
                    if (bit_cnt == CW'(BLOCK_BITS - 1)) begin
                        state         <= ST_LOAD_KEY;
                        bit_cnt       <= '0;
                        byte_cnt      <= '0;
                        core_data_rdy <= CMD_KEY;
                        core_data_in  <= 1'b0;
                    end else begin
                        bit_cnt      <= bit_cnt + CW'(1);
                        blk          <= blk >> 1;
                        core_data_in <= blk[1];
                    end
                end

                ST_LOAD_KEY: begin
                    // Fixed all-zero key.
                    core_data_in <= 1'b0;
                    if (bit_cnt == CW'(KEY_BITS - 1)) begin
                        state         <= ST_RUN;
                        bit_cnt       <= '0;
                        byte_cnt      <= '0;
                        wdog          <= '0;
                        core_data_rdy <= CMD_RUN;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                ST_RUN: begin
                    core_data_in <= 1'b0;
                    // core_valid is tested first so a valid arriving on the
                    // watchdog's last cycle still captures rather than aborts.
                    if (core_valid) begin
                        state    <= ST_CAPTURE;
                        ct       <= {core_cipher_out, ct[BLOCK_BITS-1:1]};
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        state         <= ST_COLLECT;
                        err           <= 1'b1;
                        bit_cnt       <= '0;
                        byte_cnt      <= '0;
                        in_ready      <= 1'b1;
                        busy          <= 1'b0;
                        core_data_rdy <= CMD_IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end

                ST_CAPTURE: begin
                    // Bits enter at the MSB; after BLOCK_BITS shifts the first
                    // captured bit has reached ct[0]. Neither core_valid nor
                    // the host can stall this.
                    ct <= {core_cipher_out, ct[BLOCK_BITS-1:1]};
                    if (bit_cnt == CW'(BLOCK_BITS - 2)) begin
                        state         <= ST_DRAIN;
                        bit_cnt       <= '0;
                        byte_cnt      <= '0;
                        core_data_rdy <= CMD_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                ST_DRAIN: begin
                    // First DRAIN cycle only registers byte 0 into out_data;
                    // out_valid rises the cycle after.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= ct[7:0];
                    end else if (out_ready) begin
                        if (byte_cnt == 5'(NB - 1)) begin
                            state     <= ST_COLLECT;
                            byte_cnt  <= '0;
                            bit_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                            ct       <= ct >> 8;
                            out_data <= ct[15:8];
                        end
                    end
                end

                default: begin
                    state         <= ST_COLLECT;
                    bit_cnt       <= '0;
                    byte_cnt      <= '0;
                    out_valid     <= 1'b0;
                    busy          <= 1'b0;
                    core_data_rdy <= CMD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_host_bridge.sv
`timescale 1ns/1ps
module tb_simon_host_bridge;

    typedef struct {
        logic [7:0] first;    // first plaintext byte
        logic [7:0] step;     // increment between plaintext bytes
        int         delay;    // RUN cycles before core_valid (R = delay + 1)
        int         ct_kind;  // 0: 0xA5 repeated, 1: bytes 0x00..0x0F, 2: random
        bit         toggle;   // toggle out_ready every cycle
        int         exp_lat;  // last accept to first out_valid
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       core_cipher_out = 1'b0;
    logic       core_valid = 1'b0;
    logic       in_ready, out_valid, busy, err, core_data_in;
    logic [7:0] out_data;
    logic [1:0] core_data_rdy;

    logic       t_in_valid = 1'b0;
    logic       t_out_ready = 1'b1;
    logic       t_core_valid = 1'b0;
    logic       t_core_cipher_out = 1'b0;
    logic       t_in_ready, t_out_valid, t_busy, t_err, t_core_data_in;
    logic [7:0] t_out_data;
    logic [1:0] t_core_data_rdy;

    simon_host_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err),
        .core_data_in(core_data_in), .core_data_rdy(core_data_rdy),
        .core_cipher_out(core_cipher_out), .core_valid(core_valid)
    );

    simon_host_bridge #(.TIMEOUT(64)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .out_data(t_out_data), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .busy(t_busy), .err(t_err),
        .core_data_in(t_core_data_in), .core_data_rdy(t_core_data_rdy),
        .core_cipher_out(t_core_cipher_out), .core_valid(t_core_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic       bit_q[$];
    logic [7:0] byte_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Core model: after delay+1 RUN cycles raise core_valid and stream ct_pat LSB first.
    int            core_delay = 0;
    int            run_cnt = 0;
    int            stream_idx = -1;
    logic [127:0]  ct_pat = '0;

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            run_cnt = 0;
            stream_idx = -1;
            core_valid = 1'b0;
            core_cipher_out = 1'b0;
        end else if (stream_idx >= 0) begin
            if (stream_idx == 127) begin
                stream_idx = -1;
                core_valid = 1'b0;
                core_cipher_out = 1'b0;
            end else begin
                stream_idx++;
                core_cipher_out = ct_pat[7'(stream_idx)];
            end
        end else if (core_data_rdy == 2'b11) begin
            run_cnt++;
            if (run_cnt == core_delay + 1) begin
                core_valid = 1'b1;
                stream_idx = 0;
                run_cnt = 0;
                core_cipher_out = ct_pat[0];
            end
        end else begin
            run_cnt = 0;
        end
    end

    // Scoreboard monitor: pops expected plaintext bits and ciphertext bytes.
    logic [7:0] prev_data = 8'h00;
    bit         prev_stall = 1'b0;

    always @(posedge clk) begin
        #3;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (core_data_rdy == 2'b01) begin
                if (bit_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pt_bit: got 0x%0h with no bit expected (cycle %0d)", core_data_in, cyc);
                end else begin
                    check("pt_bit", 32'(core_data_in), 32'(bit_q.pop_front()));
                end
            end
            if (core_data_rdy == 2'b10) check("key_bit", 32'(core_data_in), 0);
            if (err) check("err_with_out_valid", 32'(out_valid), 0);
            if (prev_stall) begin
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_valid", 32'(out_valid), 1);
            end
            if (out_valid && out_ready) begin
                if (byte_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_byte: got 0x%0h with no byte expected (cycle %0d)", out_data, cyc);
                end else begin
                    check("out_byte", 32'(out_data), 32'(byte_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic set_core(input int delay, input logic [127:0] pat, input bit push);
        logic [127:0] p;
        core_delay = delay;
        ct_pat = pat;
        p = pat;
        if (push) begin
            for (int m = 0; m < 16; m++) begin
                byte_q.push_back(p[7:0]);
                p = p >> 8;
            end
        end
    endtask

    task automatic feed_block(input logic [7:0] first, input logic [7:0] step, output int acc_cyc);
        int got = 0;
        int used = 0;
        logic [7:0] d = first;
        logic [7:0] s;
        acc_cyc = cyc;
        in_valid = 1'b1;
        in_data = d;
        while (got < 16 && used < 64) begin
            if (in_ready) begin
                s = d;
                for (int b = 0; b < 8; b++) begin
                    bit_q.push_back(s[0]);
                    s = s >> 1;
                end
                got++;
                acc_cyc = cyc;
                d = d + step;
            end
            used++;
            tick();
            in_data = d;
        end
        check("accept_count", got, 16);
        check("accept_cycles", used, 16);
    endtask

    task automatic run_vec(input vec_t v);
        logic [127:0] pat;
        int acc, n, errs;
        case (v.ct_kind)
            0: pat = {16{8'hA5}};
            1: for (int m = 0; m < 16; m++) pat = {8'(m), pat[127:8]};
            default: pat = {$urandom, $urandom, $urandom, $urandom};
        endcase
        set_core(v.delay, pat, 1'b1);
        out_ready = 1'b1;
        feed_block(v.first, v.step, acc);
        // in_valid stays high through LOAD_PT; none of it may be consumed.
        check("in_ready_outside_collect", 32'(in_ready), 0);
        check("busy_in_load", 32'(busy), 1);
        n = 0;
        while (core_data_rdy == 2'b01 && n < 300) begin
            n++;
            tick();
        end
        check("pt_cycles", n, 128);
        in_valid = 1'b0;
        n = 0;
        while (core_data_rdy == 2'b10 && n < 300) begin
            n++;
            tick();
        end
        check("key_cycles", n, 128);
        check("run_cmd", 32'(core_data_rdy), 3);
        errs = 0;
        while (!out_valid && (cyc - acc) < 2000) begin
            if (err) errs++;
            tick();
            if (v.toggle) out_ready = ~out_ready;
        end
        check("first_out_latency", cyc - acc, v.exp_lat);
        check("no_err", errs, 0);
        n = 0;
        while (byte_q.size() > 0 && n < 200) begin
            n++;
            tick();
            if (v.toggle) out_ready = ~out_ready;
        end
        check("bytes_left", byte_q.size(), 0);
        check("in_ready_after_drain", 32'(in_ready), 1);
        check("out_valid_after_drain", 32'(out_valid), 0);
        check("busy_after_drain", 32'(busy), 0);
        out_ready = 1'b1;
    endtask

    initial begin
        vec_t vecs[4];
        int n, acc, run_c, ov, nb, errs;
        logic [7:0] fb;

        vecs[0] = '{8'h00, 8'h01, 200, 0, 1'b0, 586};
        vecs[1] = '{8'h00, 8'h01, 5,   1, 1'b1, 391};
        vecs[2] = '{8'h3C, 8'h07, 0,   2, 1'b0, 386};
        vecs[3] = '{8'hFF, 8'h00, 3,   0, 1'b0, 389};

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cmd", 32'(core_data_rdy), 0);
        check("rst_data_in", 32'(core_data_in), 0);
        repeat (2) tick();
        check("in_ready_held_in_reset", 32'(in_ready), 0);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_release", 32'(in_ready), 1);

        // Watchdog abort with TIMEOUT=64
        t_in_valid = 1'b1;
        n = 0;
        nb = 0;
        while (nb < 16 && n < 64) begin
            in_data = 8'(nb);
            if (t_in_ready) nb++;
            n++;
            tick();
        end
        t_in_valid = 1'b0;
        check("to_accepts", nb, 16);
        n = 0;
        while (t_core_data_rdy != 2'b11 && n < 400) begin
            n++;
            tick();
        end
        check("to_reach_run", 32'(t_core_data_rdy), 3);
        run_c = cyc;
        ov = 0;
        while (!t_err && (cyc - run_c) < 200) begin
            if (t_out_valid) ov++;
            tick();
        end
        check("err_delay", cyc - run_c, 64);
        check("err_in_ready", 32'(t_in_ready), 1);
        check("err_busy", 32'(t_busy), 0);
        check("err_cmd_idle", 32'(t_core_data_rdy), 0);
        tick();
        check("err_pulse_width", 32'(t_err), 0);
        check("to_no_out_valid", ov + 32'(t_out_valid), 0);

        // core_valid on the watchdog's final cycle wins
        t_in_valid = 1'b1;
        n = 0;
        nb = 0;
        while (nb < 16 && n < 64) begin
            in_data = 8'(nb);
            if (t_in_ready) nb++;
            n++;
            tick();
        end
        t_in_valid = 1'b0;
        n = 0;
        while (t_core_data_rdy != 2'b11 && n < 400) begin
            n++;
            tick();
        end
        run_c = cyc;
        while ((cyc - run_c) < 63) tick();
        t_core_valid = 1'b1;
        t_core_cipher_out = 1'b1;
        tick();
        t_core_valid = 1'b0;
        t_core_cipher_out = 1'b0;
        check("tie_no_err", 32'(t_err), 0);
        check("tie_capture", 32'(t_core_data_rdy), 3);
        n = 0;
        nb = 0;
        errs = 0;
        fb = 8'h00;
        while (nb < 16 && n < 400) begin
            if (t_out_valid) begin
                if (nb == 0) fb = t_out_data;
                nb++;
            end
            if (t_err) errs++;
            n++;
            tick();
        end
        check("tie_bytes", nb, 16);
        check("tie_first_byte", 32'(fb), 32'h01);
        check("tie_errs", errs, 0);

        // Table-driven full blocks
        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // Reset pulse at LOAD_KEY cycle 50
        set_core(200, '0, 1'b0);
        feed_block(8'h5A, 8'h11, acc);
        in_valid = 1'b0;
        n = 0;
        while (core_data_rdy != 2'b10 && n < 300) begin
            n++;
            tick();
        end
        repeat (50) tick();
        check("pre_reset_in_key", 32'(core_data_rdy), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", 32'(core_data_rdy), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_data_in", 32'(core_data_in), 0);
        bit_q.delete();
        byte_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_in_ready_after", 32'(in_ready), 1);
        run_vec(vecs[3]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
